// File: rtl/rf_exec_unit.sv
// Execute/writeback sequencer: reads two registers, runs one ALU or shift-add multiply op,
// and writes the result back through the register file's write port.
module rf_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  raddr1,
    output logic [4:0]  raddr2,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    typedef enum logic [2:0] {StIdle, StRead, StExec, StMul, StWb, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic [31:0] result_q, result_d, wdata_q, wdata_d;
    logic [4:0]  raddr1_q, raddr1_d, raddr2_q, raddr2_d, waddr_q, waddr_d;
    logic [31:0] alu_res, acc_next;

    always_comb begin
        alu_res = 32'd0;
        unique case (op_q)
            3'b000:  alu_res = a_q + b_q;
            3'b001:  alu_res = a_q - b_q;
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
            3'b110:  alu_res = a_q << b_q[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    // a_q shifts left and b_q shifts right each step, so b_q[0] is the current multiplier bit
    assign acc_next = acc_q + (b_q[0] ? a_q : 32'd0);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        we_d     = we_q;
        result_d = result_q;
        wdata_d  = wdata_q;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        waddr_d  = waddr_q;
        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    op_d     = op;
                    rd_d     = rd;
                    raddr1_d = rs;
                    raddr2_d = rt;
                    busy_d   = 1'b1;
                    state_d  = StRead;
                end
            end
            StRead: begin
                a_d     = rdata1;
                b_d     = rdata2;
                acc_d   = 32'd0;
                cnt_d   = 5'd0;
                state_d = (op_q == 3'b111) ? StMul : StExec;
            end
            StExec: begin
                result_d = alu_res;
                state_d  = StWb;
            end
            StMul: begin
                acc_d = acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = acc_next;
                    state_d  = StWb;
                end
            end
            StWb: begin
                we_d    = (rd_q != 5'd0);
                waddr_d = rd_q;
                wdata_d = result_q;
                state_d = StDone;
            end
            StDone: begin
                we_d    = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            result_q <= 32'd0;
            wdata_q  <= 32'd0;
            raddr1_q <= 5'd0;
            raddr2_q <= 5'd0;
            waddr_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            result_q <= result_d;
            wdata_q  <= wdata_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            waddr_q  <= waddr_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we     = we_q;
    assign result = result_q;
    assign wdata  = wdata_q;
    assign raddr1 = raddr1_q;
    assign raddr2 = raddr2_q;
    assign waddr  = waddr_q;

endmodule

// File: tb/tb_rf_exec_unit.sv
// Bench for rf_exec_unit: owns a falling-edge register file model; a driver queues expected
// results and a monitor checks each done pulse, write strobe and register contents.
module tb_rf_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
    logic        busy, done, we;
    logic [31:0] result, rdata1, rdata2, wdata;
    logic [4:0]  raddr1, raddr2, waddr;

    logic [31:0] rf [32];

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        time         t0;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_done = 0;
    int   we_cnt = 0;

    always #5 clk = ~clk;

    rf_exec_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .busy   (busy),
        .done   (done),
        .result (result),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    // r0 reads as zero, but any write strobe is stored so a stray r0 write is visible
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];
    always @(negedge clk) if (we) rf[waddr] = wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (we) begin
            we_cnt++;
            if (exp_q.size() == 0) chk("stray_we", 32'd1, 32'd0);
            else begin
                chk("waddr", {27'd0, waddr}, {27'd0, exp_q[0].rd});
                chk("wdata", wdata, exp_q[0].res);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) chk("stray_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("latency", 32'(($time - 1 - e.t0) / 10), 32'(e.lat));
                chk("we_count", 32'(we_cnt), (e.rd != 5'd0) ? 32'd1 : 32'd0);
                if (e.rd != 5'd0) chk("rf_dest", rf[e.rd], e.res);
                chk("rf_r0", rdata_r0(), 32'd0);
            end
            we_cnt = 0;
            n_done++;
        end
    end

    function automatic logic [31:0] rdata_r0();
        return rf[0];
    endfunction

    task automatic issue(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [31:0] res, input int lat,
                         input bit poke);
        int prev;
        exp_t e;
        prev = n_done;
        @(negedge clk);
        op = o; rs = s; rt = t; rd = d; start = 1'b1;
        @(posedge clk);
        e.res = res; e.rd = d; e.lat = lat; e.t0 = $time;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; op = ~o; rs = ~s; rt = ~t; rd = ~d;
        if (poke) begin
            repeat (9) @(negedge clk);
            start = 1'b1; op = 3'd0; rd = 5'd20;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 60 && n_done == prev; i++) @(negedge clk);
        if (n_done == prev) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_raddr", {22'd0, raddr1, raddr2}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wport", wdata | {27'd0, waddr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        rf[1] = 32'd5; rf[2] = 32'd7;
        issue(3'b000, 5'd1, 5'd2, 5'd3, 32'd12, 4, 1'b0);
        issue(3'b000, 5'd1, 5'd2, 5'd0, 32'd12, 4, 1'b0);

        rf[1] = 32'h8000_0000; rf[2] = 32'd1;
        issue(3'b001, 5'd1, 5'd2, 5'd4, 32'h7FFF_FFFF, 4, 1'b0);
        issue(3'b101, 5'd1, 5'd2, 5'd5, 32'd1, 4, 1'b0);
        issue(3'b101, 5'd2, 5'd1, 5'd12, 32'd0, 4, 1'b0);

        rf[1] = 32'hF0F0_1234; rf[2] = 32'h0FF0_0024;
        issue(3'b010, 5'd1, 5'd2, 5'd8, 32'h00F0_0024, 4, 1'b0);
        issue(3'b011, 5'd1, 5'd2, 5'd9, 32'hFFF0_1234, 4, 1'b0);
        issue(3'b100, 5'd1, 5'd2, 5'd10, 32'hFF00_1210, 4, 1'b0);
        issue(3'b110, 5'd1, 5'd2, 5'd11, 32'h0F01_2340, 4, 1'b0);

        rf[1] = 32'hFFFF_FFFF; rf[2] = 32'hFFFF_FFFF;
        issue(3'b111, 5'd1, 5'd2, 5'd6, 32'd1, 35, 1'b1);
        rf[1] = 32'h1234_5678; rf[2] = 32'd9;
        issue(3'b111, 5'd1, 5'd2, 5'd13, 32'hA3D7_0A38, 35, 1'b0);

        rf[1] = 32'd3;
        issue(3'b000, 5'd1, 5'd1, 5'd1, 32'd6, 4, 1'b0);

        // Abort a multiply at MUL cycle 20: no write, no done
        rf[7] = 32'hDEAD_BEEF;
        @(negedge clk);
        op = 3'b111; rs = 5'd1; rt = 5'd2; rd = 5'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_we", {31'd0, we}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_rf7", rf[7], 32'hDEAD_BEEF);

        // Reset and start together: command dropped
        rst = 1'b1; start = 1'b1; op = 3'b000; rs = 5'd1; rt = 5'd1; rd = 5'd14;
        @(posedge clk);
        #1;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_start_rf14", rf[14], 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/rf_exec_unit.md
# rf_exec_unit

Multi-cycle execute/writeback sequencer that sits beside the 32×32 register file and drives both its read and write ports. On a `start` command it:

- reads two source registers,
- computes one of eight ALU/multiply operations,
- writes the result back to a destination register.

It is the datapath stage that feeds the register file's write port and consumes its two read ports.

## Interface
Parameters: none; all widths fixed at 32-bit data and 5-bit register addresses.

- clk  in  1  system clock. Rising-edge logic; the register file writes on the falling edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe. Sampled only in IDLE.
- op  in  3  operation code.
- rs  in  5  source register 1 address.
- rt  in  5  source register 2 address.
- rd  in  5  destination register address.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.
- result  out  32  last computed result. Held until the next result is computed.
- raddr1  out  5  to register file read port 1.
- raddr2  out  5  to register file read port 2.
- rdata1  in  32  from register file read port 1.
- rdata2  in  32  from register file read port 2.
- we  out  1  register file write enable.
- waddr  out  5  register file write address.
- wdata  out  32  register file write data.

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, result=0, raddr1=0, raddr2=0, we=0, waddr=0, wdata=0. State goes to IDLE.
- State machine:
  - IDLE: on start=1, latch op/rs/rt/rd; drive raddr1=rs, raddr2=rt; busy=1; go to READ. start=0 stays in IDLE.
  - READ: we=0, so the register file read ports are enabled. Latch A=rdata1, B=rdata2. Go to MUL if op=111, else EXEC.
  - EXEC: compute the result into `result` in one cycle, then go to WB.
  - MUL: shift-add multiply, one multiplier bit per cycle over 32 cycles. Counter runs 0..31. When count=31, `result` = low 32 bits of A×B; go to WB.
  - WB: we=(rd≠0), waddr=rd, wdata=result for exactly one cycle. Go to DONE.
  - DONE: done=1, busy=1 for one cycle; drop we. Go to IDLE.
- Op encoding (all arithmetic modulo 2^32, no overflow flag):
  - 000 ADD A+B
  - 001 SUB A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: 1 if A<B signed, else 0
  - 110 SLL: A << B[4:0]
  - 111 MUL: low 32 bits of A×B, unsigned
- rd=0: the computation runs and `result` and done update, but we stays 0, so r0 is never written.
- start while busy is ignored. It is not queued.
- Changes on op/rs/rt/rd after the IDLE sample have no effect.
- rs or rt may equal rd. Operands are latched in READ, before WB, so this is safe.

## Timing
- Cycle 0 is the rising edge on which start=1 is sampled in IDLE.
- Non-MUL ops:
  - READ during cycle 1, EXEC cycle 2, WB cycle 3, DONE cycle 4.
  - done is high for the single cycle following edge 4.
  - Next start is accepted at edge 5.
- MUL:
  - READ cycle 1, MUL cycles 2–33, WB cycle 34, DONE cycle 35.
- we/waddr/wdata are stable for the whole WB cycle, so the register file's falling-edge write captures them mid-cycle.
- rdata is sampled only in READ, where we=0 is guaranteed.
- rst=1 at any rising edge, including mid-MUL or in WB:
  - next cycle is IDLE with all outputs at reset values;
  - an aborted op produces no write and no done.
- rst and start both high: reset wins, and the command is dropped.

## Test plan
- Preload r1=5, r2=7 via the register file write port. ADD rs=1 rt=2 rd=3 → done 4 cycles after start; r3=12; result=12.
- Preload r1=0x80000000, r2=1. SUB rd=4 → r4=0x7FFFFFFF. SLT rs=1 rt=2 rd=5 → r5=1 (signed).
- Preload r1=0xFFFFFFFF, r2=0xFFFFFFFF. MUL rd=6 → done exactly 35 cycles after start; r6=0x00000001. A second start pulse at cycle 10 is ignored.
- ADD with rd=0 → we never asserts; done pulses; r0 still reads 0.
- Preload r1=3. ADD rs=1 rt=1 rd=1 → r1=6 (operand latched before writeback).
- Assert rst in MUL cycle 20 → busy=0 and we=0 the next cycle; destination register unchanged; no done pulse.
